filter_frame_collector: RTL and testbench

FILTER_FRAME_COLLECTOR -- requirements
Module: filter_frame_collector

---
 rtl/filter_frame_collector_pkg.sv | 30 +++
 rtl/frame_ram.sv | 27 ++
 rtl/filter_frame_collector.sv | 136 +++++++++++++
 tb/tb_filter_frame_collector.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_frame_collector_pkg.sv
// Shared definitions for the filter frame collector: size helpers and FSM encoding.
package filter_frame_collector_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFill  = 2'd1,
        StDrain = 2'd2
    } state_e;

    // Ceiling log2; clog2(1) == 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    // Inner pixels of a 3x3-filtered image: the two leading rows/columns are border.
    function automatic int unsigned frame_pixels(input int unsigned cols, input int unsigned rows);
        return (cols - 2) * (rows - 2);
    endfunction

    // Address width wide enough to hold the value N itself.
    function automatic int unsigned addr_width(input int unsigned cols, input int unsigned rows);
        return clog2(frame_pixels(cols, rows)) + 1;
    endfunction

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame buffer: synchronous write, registered read, contents never reset.
module frame_ram #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned ADDRW = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ADDRW-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [ADDRW-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write port and registered read port; rdata holds when re is low.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/filter_frame_collector.sv
// Collects the inner region of one filtered frame into a buffer, then streams it out
// in raster order over a valid/ready interface.
module filter_frame_collector
    import filter_frame_collector_pkg::*;
#(
    parameter int unsigned BITWIDTH = 8,
    parameter int unsigned COLS     = 6,
    parameter int unsigned ROWS     = 6,
    localparam int unsigned N       = frame_pixels(COLS, ROWS),
    localparam int unsigned AW      = addr_width(COLS, ROWS),
    localparam int unsigned XW      = clog2(COLS) + 1,
    localparam int unsigned YW      = clog2(ROWS) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    input  logic [BITWIDTH-1:0] in_data,
    input  logic [XW-1:0]       in_x,
    input  logic [YW-1:0]       in_y,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BITWIDTH-1:0] out_data,
    output logic [AW-1:0]       out_addr,
    output logic                out_last,
    output logic                frame_done,
    output logic                overrun
);

    localparam int unsigned RW = (clog2(N) > 0) ? clog2(N) : 1;

    state_e              state_q, state_d;
    logic [AW-1:0]       waddr_q, waddr_d;
    logic [AW-1:0]       raddr_q, raddr_d;     // next buffer address to fetch
    logic [AW-1:0]       out_addr_q, out_addr_d;
    logic                out_valid_q, out_valid_d;
    logic                frame_done_q, frame_done_d;
    logic                overrun_q, overrun_d;
    logic                inner, accept, drop, last, fetch;
    logic [BITWIDTH-1:0] rdata;

    assign inner  = in_valid && (in_x >= XW'(2)) && (in_y >= YW'(2));
    assign accept = inner && (state_q == StFill);
    assign drop   = inner && (state_q != StFill);
    assign last   = out_valid_q && (out_addr_q == AW'(N - 1));

    // Next-state logic for the fill/drain sequencer.
    always_comb begin
        state_d      = state_q;
        waddr_d      = waddr_q;
        raddr_d      = raddr_q;
        out_addr_d   = out_addr_q;
        out_valid_d  = out_valid_q;
        frame_done_d = 1'b0;
        fetch        = 1'b0;
        overrun_d    = overrun_q;

        // A drop in the same cycle as start still leaves overrun set.
        if (start && (state_q == StIdle)) overrun_d = 1'b0;
        if (drop) overrun_d = 1'b1;

        unique case (state_q)
            StIdle: begin
                if (start) state_d = StFill;
            end
            StFill: begin
                if (accept) begin
                    if (waddr_q == AW'(N - 1)) begin
                        waddr_d      = '0;
                        frame_done_d = 1'b1;
                        state_d      = StDrain;
                    end else begin
                        waddr_d = waddr_q + AW'(1);
                    end
                end
            end
            StDrain: begin
                if (last && out_ready) begin
                    out_valid_d = 1'b0;
                    raddr_d     = '0;
                    state_d     = StIdle;
                end else if (!out_valid_q || out_ready) begin
                    // Prefetch the next word so transfers can go every cycle.
                    fetch       = 1'b1;
                    out_valid_d = 1'b1;
                    out_addr_d  = raddr_q;
                    raddr_d     = raddr_q + AW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; buffer contents are deliberately left out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            waddr_q      <= '0;
            raddr_q      <= '0;
            out_addr_q   <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            waddr_q      <= waddr_d;
            raddr_q      <= raddr_d;
            out_addr_q   <= out_addr_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    frame_ram #(
        .WIDTH (BITWIDTH),
        .DEPTH (N),
        .ADDRW (RW)
    ) u_frame_ram (
        .clk   (clk),
        .we    (accept),
        .waddr (waddr_q[RW-1:0]),
        .wdata (in_data),
        .re    (fetch),
        .raddr (raddr_q[RW-1:0]),
        .rdata (rdata)
    );

    assign out_valid  = out_valid_q;
    assign out_data   = out_valid_q ? rdata : '0;
    assign out_addr   = out_valid_q ? out_addr_q : '0;
    assign out_last   = last;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_filter_frame_collector.sv
// Directed + randomized bench for filter_frame_collector against a queue-based frame model.
module tb_filter_frame_collector;

    localparam int BW   = 8;
    localparam int COLS = 6;
    localparam int ROWS = 6;
    localparam int N    = (COLS - 2) * (ROWS - 2);
    localparam int AW   = 5;
    localparam int XW   = 4;
    localparam int YW   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [BW-1:0] in_data;
    logic [XW-1:0] in_x;
    logic [YW-1:0] in_y;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_last;
    logic          frame_done;
    logic          overrun;

    int vectors    = 0;
    int miscompares = 0;

    // Model: pixels expected out of the current frame, and the sticky drop flag.
    logic [BW-1:0] exp_q[$];
    bit            ov_model = 1'b0;

    always #5 clk = ~clk;

    filter_frame_collector #(
        .BITWIDTH (BW),
        .COLS     (COLS),
        .ROWS     (ROWS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_x       (in_x),
        .in_y       (in_y),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .out_last   (out_last),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 0);
        chk({tag, "_data"}, 32'(out_data), 0);
        chk({tag, "_addr"}, 32'(out_addr), 0);
        chk({tag, "_last"}, 32'(out_last), 0);
        chk({tag, "_done"}, 32'(frame_done), 0);
        chk({tag, "_ovr"}, 32'(overrun), 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_zero(tag);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        ov_model = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        chk("pre_start_ovr", 32'(overrun), 32'(ov_model));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ov_model = 1'b0;
        chk("start_clr_ovr", 32'(overrun), 0);
    endtask

    // Drive a raster scan; stops after max_accept inner pixels when armed.
    task automatic feed(input bit armed, input bit rnd, input int max_accept, input int gap_pct);
        int  accepted = 0;
        bit  fd_pend  = 1'b0;
        bit  stop     = 1'b0;
        for (int y = 0; y < ROWS && !stop; y++) begin
            for (int x = 0; x < COLS && !stop; x++) begin
                while ($urandom_range(99) < 32'(gap_pct)) begin
                    @(negedge clk);
                    chk("fill_done", 32'(frame_done), 32'(fd_pend));
                    chk("fill_ovr", 32'(overrun), 32'(ov_model));
                    chk("fill_valid", 32'(out_valid), 0);
                    fd_pend  = 1'b0;
                    in_valid = 1'b0;
                end
                @(negedge clk);
                chk("fill_done", 32'(frame_done), 32'(fd_pend));
                chk("fill_ovr", 32'(overrun), 32'(ov_model));
                chk("fill_valid", 32'(out_valid), 0);
                fd_pend  = 1'b0;
                in_valid = 1'b1;
                in_x     = XW'(x);
                in_y     = YW'(y);
                in_data  = rnd ? BW'($urandom) : BW'(16 * y + x);
                if (x >= 2 && y >= 2) begin
                    if (armed) begin
                        accepted++;
                        exp_q.push_back(in_data);
                        if (accepted == N) begin
                            fd_pend = 1'b1;
                            armed   = 1'b0;
                        end
                        if (accepted == max_accept) stop = 1'b1;
                    end else begin
                        ov_model = 1'b1;
                    end
                end
            end
        end
        @(negedge clk);
        chk("fill_done", 32'(frame_done), 32'(fd_pend));
        chk("fill_ovr", 32'(overrun), 32'(ov_model));
        chk("fill_valid", 32'(out_valid), 0);
        in_valid = 1'b0;
    endtask

    // mode 0: always ready, 1: toggling, 2: random. reset_at >= 0 resets mid-drain.
    task automatic drain(input int mode, input bit inject, input int reset_at);
        int idx = 0;
        int cyc = 0;
        bit rdy = 1'b0;
        bit done = 1'b0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            in_valid = 1'b0;
            if (idx == reset_at) begin
                rst = 1'b0;
                #1;
                check_zero("drain_rst");
                @(negedge clk);
                rst       = 1'b1;
                out_ready = 1'b0;
                exp_q.delete();
                ov_model  = 1'b0;
                return;
            end
            if (out_valid) begin
                chk("out_data", 32'(out_data), 32'(exp_q[idx]));
                chk("out_addr", 32'(out_addr), 32'(idx));
                chk("out_last", 32'(out_last), 32'(idx == N - 1));
            end else begin
                chk("idle_data", 32'(out_data), 0);
                chk("idle_addr", 32'(out_addr), 0);
            end
            chk("drain_ovr", 32'(overrun), 32'(ov_model));
            chk("drain_done", 32'(frame_done), 0);
            case (mode)
                0: rdy = 1'b1;
                1: rdy = ~rdy;
                default: rdy = 1'($urandom_range(1));
            endcase
            out_ready = rdy;
            if (out_valid && rdy) begin
                if (idx == N - 1) done = 1'b1;
                idx++;
            end
            if (inject && cyc == 3) begin
                in_valid = 1'b1;
                in_x     = XW'(3);
                in_y     = YW'(3);
                in_data  = 8'hee;
                ov_model = 1'b1;
            end
        end
        chk("drain_count", 32'(idx), 32'(N));
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("post_valid", 32'(out_valid), 0);
        chk("post_data", 32'(out_data), 0);
        chk("post_ovr", 32'(overrun), 32'(ov_model));
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_x      = '0;
        in_y      = '0;
        out_ready = 1'b0;
        #12;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        // Reference frame, always ready.
        pulse_start();
        feed(1'b1, 1'b0, N, 0);
        drain(0, 1'b0, -1);

        // Same frame, consumer stalls every other cycle.
        pulse_start();
        feed(1'b1, 1'b0, N, 0);
        drain(1, 1'b0, -1);

        // Inner pixel injected while draining; next start clears the flag.
        pulse_start();
        feed(1'b1, 1'b0, N, 0);
        drain(0, 1'b1, -1);
        pulse_start();
        feed(1'b1, 1'b1, N, 20);
        drain(2, 1'b0, -1);

        // Reset after 7 accepted pixels, then a clean frame.
        pulse_start();
        feed(1'b1, 1'b0, 7, 0);
        do_reset("fill_rst");
        pulse_start();
        feed(1'b1, 1'b0, N, 0);
        drain(0, 1'b0, -1);

        // Reset in the middle of draining, then a clean frame.
        pulse_start();
        feed(1'b1, 1'b0, N, 0);
        drain(0, 1'b0, 5);
        pulse_start();
        feed(1'b1, 1'b0, N, 0);
        drain(1, 1'b0, -1);

        // Pixels with no start: nothing collected, overrun on first inner pixel.
        feed(1'b0, 1'b0, N, 0);
        pulse_start();
        feed(1'b1, 1'b1, N, 10);
        drain(2, 1'b0, -1);

        // Randomized frames with input gaps and random backpressure.
        for (int f = 0; f < 4; f++) begin
            pulse_start();
            feed(1'b1, 1'b1, N, 30);
            drain(2, (f == 1), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
